// File: rtl/fp_sig_divider_if.sv
// Request/response handshake bundle for the significand divider.
// slave = divider side, master = issuing/consuming side.
interface fp_sig_divider_if #(
  parameter int SIG_WIDTH = 24,
  parameter int TAG_WIDTH = 2
);
  localparam int QBITS = SIG_WIDTH + 2;

  logic                 req_valid;
  logic                 req_ready;
  logic [TAG_WIDTH-1:0] req_thread_idx;
  logic [SIG_WIDTH-1:0] req_dividend;
  logic [SIG_WIDTH-1:0] req_divisor;

  logic                 resp_valid;
  logic                 resp_ready;
  logic [TAG_WIDTH-1:0] resp_thread_idx;
  logic [QBITS-1:0]     resp_quotient;
  logic                 resp_sticky;
  logic                 resp_div_zero;

  modport slave (
    input  req_valid, req_thread_idx,
    input  req_dividend, req_divisor,
    input  resp_ready,
    output req_ready, resp_valid,
    output resp_thread_idx, resp_quotient,
    output resp_sticky, resp_div_zero
  );

  modport master (
    output req_valid, req_thread_idx,
    output req_dividend, req_divisor,
    output resp_ready,
    input  req_ready, resp_valid,
    input  resp_thread_idx, resp_quotient,
    input  resp_sticky, resp_div_zero
  );
endinterface

// File: rtl/fp_sig_divider.sv
// Radix-2 restoring divider for normalized FP significands.
// One request in flight; rollback of the owning thread kills it.
module fp_sig_divider #(
  parameter int SIG_WIDTH = 24,
  parameter int TAG_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_rollback_en,
  input  logic [TAG_WIDTH-1:0] wb_rollback_thread_idx,
  fp_sig_divider_if.slave      bus
);
  localparam int QBITS = SIG_WIDTH + 2;
  localparam int CW    = $clog2(QBITS);
  localparam logic [CW-1:0] LAST = CW'(QBITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [SIG_WIDTH-1:0] div_q, div_d;
  logic [SIG_WIDTH:0]   rem_q, rem_d;
  logic [QBITS-1:0]     quo_q, quo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sticky_q, sticky_d;
  logic                 dz_q, dz_d;

  logic               rb_hit;
  logic               rb_req;
  logic               ge;
  logic [SIG_WIDTH:0] rem_nx;

  assign rb_hit = wb_rollback_en &&
                  (wb_rollback_thread_idx == tag_q);
  assign rb_req = wb_rollback_en &&
                  (wb_rollback_thread_idx == bus.req_thread_idx);

  // rem < 2*div always, so the difference fits without underflow
  assign ge     = rem_q >= {1'b0, div_q};
  assign rem_nx = ge ? (rem_q - {1'b0, div_q}) : rem_q;

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    div_d    = div_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    dz_d     = dz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && !rb_req) begin
          tag_d    = bus.req_thread_idx;
          div_d    = bus.req_divisor;
          rem_d    = {1'b0, bus.req_dividend};
          quo_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
          if (bus.req_divisor == '0) begin
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            dz_d    = 1'b0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (rb_hit) begin
          state_d = IDLE;
        end else begin
          quo_d = {quo_q[QBITS-2:0], ge};
          rem_d = {rem_nx[SIG_WIDTH-1:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            sticky_d = |rem_nx;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (rb_hit || bus.resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.req_ready       = (state_q == IDLE);
  assign bus.resp_valid      = (state_q == DONE);
  assign bus.resp_thread_idx = tag_q;
  assign bus.resp_quotient   = quo_q;
  assign bus.resp_sticky     = sticky_q;
  assign bus.resp_div_zero   = dz_q;
endmodule

// File: tb/tb_fp_sig_divider.sv
// Scoreboard bench for fp_sig_divider: driver queues expected
// results, a negedge monitor checks each accepted response.
module tb_fp_sig_divider;
  localparam int SW = 24;
  localparam int TW = 2;
  localparam int QB = SW + 2;

  typedef struct {
    logic [TW-1:0] tag;
    logic [QB-1:0] q;
    logic          st;
    logic          dz;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rb_en = 1'b0;
  logic [TW-1:0] rb_idx = '0;

  int total = 0;
  int bad = 0;
  exp_t sb[$];

  fp_sig_divider_if #(.SIG_WIDTH(SW), .TAG_WIDTH(TW)) bus ();

  fp_sig_divider #(.SIG_WIDTH(SW), .TAG_WIDTH(TW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .wb_rollback_en         (rb_en),
    .wb_rollback_thread_idx (rb_idx),
    .bus                    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic tmo(string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout", nm);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got q=%h want none",
                 bus.resp_quotient);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_tag", 32'(bus.resp_thread_idx), 32'(e.tag));
        chk("resp_q", 32'(bus.resp_quotient), 32'(e.q));
        chk("resp_sticky", 32'(bus.resp_sticky), 32'(e.st));
        chk("resp_dz", 32'(bus.resp_div_zero), 32'(e.dz));
      end
    end
  end

  task automatic send(input logic [TW-1:0] tag,
                      input logic [SW-1:0] dd,
                      input logic [SW-1:0] dv,
                      input bit push,
                      input logic [QB-1:0] q,
                      input logic st);
    int n;
    exp_t e;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) tmo("req_ready");
    bus.req_valid      = 1'b1;
    bus.req_thread_idx = tag;
    bus.req_dividend   = dd;
    bus.req_divisor    = dv;
    if (push) begin
      e.tag = tag;
      e.q   = q;
      e.st  = st;
      e.dz  = (dv == '0);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.resp_valid && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.resp_valid) tmo("resp_valid");
  endtask

  initial begin
    int n;
    bus.req_valid      = 1'b0;
    bus.req_thread_idx = '0;
    bus.req_dividend   = '0;
    bus.req_divisor    = '0;
    bus.resp_ready     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_q", 32'(bus.resp_quotient), 32'd0);
    chk("rst_sticky", 32'(bus.resp_sticky), 32'd0);
    chk("rst_dz", 32'(bus.resp_div_zero), 32'd0);
    chk("rst_tag", 32'(bus.resp_thread_idx), 32'd0);

    // 1.5 / 1.0 with latency
    send(2'd1, 24'hC00000, 24'h800000, 1, 26'h3000000, 1'b0);
    chk("busy_no_valid", 32'(bus.resp_valid), 32'd0);
    wait_valid(n);
    chk("latency", 32'(n), 32'd27);
    @(posedge clk); #1;

    // 1.0 / 1.5 with consumer stall
    bus.resp_ready = 1'b0;
    send(2'd0, 24'h800000, 24'hC00000, 1, 26'h1555555, 1'b1);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      chk("stall_q", 32'(bus.resp_quotient), 32'h1555555);
      chk("stall_sticky", 32'(bus.resp_sticky), 32'd1);
      chk("stall_valid", 32'(bus.resp_valid), 32'd1);
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_pop_ready", 32'(bus.req_ready), 32'd1);

    // divide by zero
    send(2'd2, 24'hA00000, 24'h000000, 1, 26'h0, 1'b0);
    chk("dz_valid", 32'(bus.resp_valid), 32'd1);
    chk("dz_flag", 32'(bus.resp_div_zero), 32'd1);
    chk("dz_tag", 32'(bus.resp_thread_idx), 32'd2);
    chk("dz_q", 32'(bus.resp_quotient), 32'd0);
    @(posedge clk); #1;

    // rollback of the in-flight thread at count 10
    send(2'd1, 24'hC00000, 24'h800000, 0, 26'h0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rb_en  = 1'b1;
    rb_idx = 2'd1;
    @(posedge clk); #1;
    rb_en = 1'b0;
    chk("rb_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rb_no_valid", 32'(bus.resp_valid), 32'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("rb_still_idle", 32'(bus.req_ready), 32'd1);

    // rollback of another thread is ignored
    rb_en  = 1'b1;
    rb_idx = 2'd3;
    send(2'd1, 24'hC00000, 24'h800000, 1, 26'h3000000, 1'b0);
    wait_valid(n);
    rb_en = 1'b0;
    chk("rb_other_lat", 32'(n), 32'd27);
    @(posedge clk); #1;

    // rollback in IDLE swallows the matching request
    rb_en  = 1'b1;
    rb_idx = 2'd0;
    send(2'd0, 24'hC00000, 24'h800000, 0, 26'h0, 1'b0);
    rb_en = 1'b0;
    chk("idle_rb_ready", 32'(bus.req_ready), 32'd1);
    chk("idle_rb_valid", 32'(bus.resp_valid), 32'd0);

    // reset mid-operation
    send(2'd0, 24'hFFFFFF, 24'h800000, 0, 26'h0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_q", 32'(bus.resp_quotient), 32'd0);

    // back-to-back boundary operands
    send(2'd0, 24'hFFFFFF, 24'h800000, 1, 26'h3FFFFFC, 1'b0);
    send(2'd3, 24'h800000, 24'hFFFFFF, 1, 26'h1000001, 1'b1);
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
